// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions: FSM state encoding, default line
//               rates and 8N1 frame constants (shared with the transmitter).
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int DEF_CLK_FREQ  = 50000000;
  localparam int DEF_BAUD_RATE = 9600;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

endpackage
`default_nettype wire

// File: rtl/uart_sync.sv
`default_nettype none
// ============================================================================
// Module      : uart_sync
// Description : Two-flop synchroniser for a single asynchronous input, with
//               a configurable reset value.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 8N1 asynchronous serial receiver with one-cycle valid and
//               framing-error strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = DEF_CLK_FREQ,
  parameter int BAUD_RATE = DEF_BAUD_RATE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int CPB  = CLK_FREQ / BAUD_RATE;
  localparam int HALF = CPB / 2;

  localparam logic [15:0] c_cpb_m1   = 16'(CPB - 1);
  localparam logic [15:0] c_half_m1  = 16'(HALF - 1);
  localparam logic [2:0]  c_last_bit = 3'(DATA_BITS - 1);

  logic       w_rx_s;
  logic [2:0] r_state,     w_state_nxt;
  logic [15:0] r_cnt,      w_cnt_nxt;
  logic [2:0] r_bit_idx,   w_bit_idx_nxt;
  logic [7:0] r_shreg,     w_shreg_nxt;
  logic [7:0] r_rx_data,   w_rx_data_nxt;
  logic       r_rx_valid,  w_rx_valid_nxt;
  logic       r_frame_err, w_frame_err_nxt;
  logic       w_bit_end;
  logic       w_half_end;

  uart_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (rx_in),
    .o_sync  (w_rx_s)
  );

  assign w_bit_end  = (r_cnt == c_cpb_m1);
  assign w_half_end = (r_cnt == c_half_m1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 16'd0;
      r_bit_idx   <= 3'd0;
      r_shreg     <= 8'h00;
      r_rx_data   <= 8'h00;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_bit_idx   <= w_bit_idx_nxt;
      r_shreg     <= w_shreg_nxt;
      r_rx_data   <= w_rx_data_nxt;
      r_rx_valid  <= w_rx_valid_nxt;
      r_frame_err <= w_frame_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_bit_idx_nxt = r_bit_idx;
    w_shreg_nxt   = r_shreg;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = 16'd0;
        if (!w_rx_s) w_state_nxt = ST_START;
      end
      ST_START: begin
        if (w_half_end) begin
          w_cnt_nxt     = 16'd0;
          w_bit_idx_nxt = 3'd0;
          // A start bit that is high again at mid-bit was only a glitch.
          w_state_nxt   = w_rx_s ? ST_IDLE : ST_DATA;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      ST_DATA: begin
        if (w_bit_end) begin
          w_cnt_nxt              = 16'd0;
          w_shreg_nxt[r_bit_idx] = w_rx_s;
          if (r_bit_idx == c_last_bit) w_state_nxt = ST_STOP;
          else                         w_bit_idx_nxt = r_bit_idx + 3'd1;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      ST_STOP: begin
        if (w_bit_end) begin
          w_cnt_nxt   = 16'd0;
          w_state_nxt = w_rx_s ? ST_IDLE : ST_BREAK;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      ST_BREAK: begin
        // A held-low line must return high before a new start can arm.
        if (w_rx_s) w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 16'd0;
      end
    endcase
  end

  always_comb begin
    w_rx_data_nxt   = r_rx_data;
    w_rx_valid_nxt  = 1'b0;
    w_frame_err_nxt = 1'b0;
    if (r_state == ST_STOP && w_bit_end) begin
      if (w_rx_s) begin
        w_rx_data_nxt  = r_shreg;
        w_rx_valid_nxt = 1'b1;
      end else begin
        w_frame_err_nxt = 1'b1;
      end
    end
  end

  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;
  assign rx_busy   = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Directed, table-driven bench for uart_rx (CPB=16) plus one
//               frame at the default 50 MHz / 9600 baud rate.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  localparam int CPB     = 16;
  localparam int LAT     = 2 + 8 + 9 * CPB;   // E0 to strobe-setting edge
  localparam int DEF_CPB = 50000000 / 9600;
  localparam int DEF_LAT = 2 + DEF_CPB / 2 + 9 * DEF_CPB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_in = 1'b1;
  logic rx_in_def = 1'b1;
  logic [7:0] rx_data, rx_data_def;
  logic rx_valid, frame_err, rx_busy;
  logic rx_valid_def, frame_err_def, rx_busy_def;

  always #5 clk = ~clk;

  uart_rx #(.CLK_FREQ(16), .BAUD_RATE(1)) u_dut (
    .clk(clk), .rst(rst), .rx_in(rx_in), .rx_data(rx_data),
    .rx_valid(rx_valid), .frame_err(frame_err), .rx_busy(rx_busy)
  );

  uart_rx u_dut_def (
    .clk(clk), .rst(rst), .rx_in(rx_in_def), .rx_data(rx_data_def),
    .rx_valid(rx_valid_def), .frame_err(frame_err_def), .rx_busy(rx_busy_def)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int valid_cnt = 0, ferr_cnt = 0, both_cnt = 0, last_pulse = 0;
  int busy_seen = 0;
  int stamps[$];
  logic [7:0] datas[$];
  int def_valid_cnt = 0, def_ferr_cnt = 0, def_stamp = 0;

  always @(negedge clk) begin
    if (rx_valid) begin
      valid_cnt++;
      last_pulse = cyc;
      stamps.push_back(cyc);
      datas.push_back(rx_data);
    end
    if (frame_err) begin
      ferr_cnt++;
      last_pulse = cyc;
    end
    if (rx_valid && frame_err) both_cnt++;
    if (rx_busy) busy_seen = 1;
    if (rx_valid_def) begin
      def_valid_cnt++;
      def_stamp = cyc;
    end
    if (frame_err_def) def_ferr_cnt++;
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    valid_cnt = 0; ferr_cnt = 0; busy_seen = 0;
    stamps.delete(); datas.delete();
  endtask

  // Called at a negedge; returns at a negedge 10*CPB cycles later.
  task automatic send_frame(input logic [7:0] d, input logic stop, output int e0);
    e0 = cyc + 1;
    rx_in = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_in = d[i];
      repeat (CPB) @(negedge clk);
    end
    rx_in = stop;
    repeat (CPB) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_valid;
    int         exp_ferr;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[4];
  int e0, e1;

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
    vecs[1] = '{8'h3C, 1'b0, 0, 1, 8'hA5};
    vecs[2] = '{8'h5A, 1'b1, 1, 0, 8'h5A};
    vecs[3] = '{8'h81, 1'b1, 1, 0, 8'h81};

    repeat (3) @(negedge clk);
    check("reset rx_data", rx_data, 8'h00);
    check("reset rx_valid", rx_valid, 0);
    check("reset frame_err", frame_err, 0);
    check("reset rx_busy", rx_busy, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      clear_mon();
      send_frame(vecs[v].data, vecs[v].stop, e0);
      if (!vecs[v].stop) begin
        repeat (40) @(negedge clk);
        check("break busy held", rx_busy, 1);
        rx_in = 1'b1;
      end
      repeat (20) @(negedge clk);
      check($sformatf("vec%0d valid count", v), valid_cnt, vecs[v].exp_valid);
      check($sformatf("vec%0d ferr count", v), ferr_cnt, vecs[v].exp_ferr);
      check($sformatf("vec%0d rx_data", v), rx_data, vecs[v].exp_data);
      check($sformatf("vec%0d pulse cycle", v), last_pulse, e0 + LAT);
      check($sformatf("vec%0d busy idle", v), rx_busy, 0);
    end

    // Glitch: 3-cycle low pulse
    clear_mon();
    rx_in = 1'b0;
    repeat (3) @(negedge clk);
    rx_in = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch busy seen", busy_seen, 1);
    check("glitch busy idle", rx_busy, 0);
    check("glitch valid count", valid_cnt, 0);
    check("glitch ferr count", ferr_cnt, 0);
    check("glitch rx_data", rx_data, 8'h81);

    // Back-to-back frames, no idle gap
    clear_mon();
    send_frame(8'h00, 1'b1, e0);
    send_frame(8'hFF, 1'b1, e1);
    repeat (20) @(negedge clk);
    check("b2b valid count", valid_cnt, 2);
    if (valid_cnt == 2) begin
      check("b2b first stamp", stamps[0], e0 + LAT);
      check("b2b spacing", stamps[1] - stamps[0], 160);
      check("b2b first data", datas[0], 8'h00);
      check("b2b second data", datas[1], 8'hFF);
    end

    // Reset during data bit 4 of 0x81
    clear_mon();
    rx_in = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx_in = (i == 0);
      repeat (CPB) @(negedge clk);
    end
    rx_in = 1'b0;
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst rx_data", rx_data, 8'h00);
    check("midrst rx_valid", rx_valid, 0);
    check("midrst frame_err", frame_err, 0);
    check("midrst rx_busy", rx_busy, 0);
    @(negedge clk);
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    check("midrst no valid", valid_cnt, 0);
    check("midrst no ferr", ferr_cnt, 0);
    send_frame(8'h42, 1'b1, e0);
    repeat (20) @(negedge clk);
    check("after rst valid count", valid_cnt, 1);
    check("after rst rx_data", rx_data, 8'h42);
    check("after rst pulse cycle", last_pulse, e0 + LAT);

    check("valid and ferr together", both_cnt, 0);

    // One frame 0x55 at the default 50 MHz / 9600 rate
    e0 = cyc + 1;
    rx_in_def = 1'b0;
    repeat (DEF_CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_in_def = (8'h55 >> i) & 1'b1;
      repeat (DEF_CPB) @(negedge clk);
    end
    rx_in_def = 1'b1;
    repeat (DEF_CPB + 20) @(negedge clk);
    check("default valid count", def_valid_cnt, 1);
    check("default ferr count", def_ferr_cnt, 0);
    check("default rx_data", rx_data_def, 8'h55);
    check("default pulse cycle", def_stamp, e0 + DEF_LAT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver, the downstream partner of the team's UART transmitter: it consumes the 8N1 serial line (start bit, 8 data bits LSB first, 1 stop bit, idle high) and presents each received byte as a parallel word with a one-cycle valid strobe. It sits between the board RX pin (or a loopback of the TX serial output) and the byte consumer, and flags framing errors.

## Interface
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD_RATE, 9600, line bit rate in bits/s.
- Derived constants:
  - CPB = CLK_FREQ/BAUD_RATE (integer division), clocks per bit.
  - HALF = CPB/2.
  - CPB must lie in 4..65535.

- clk  input  1  system clock, rising edge.
- rst  input  1  reset; asynchronous and active-high.
- rx_in  input  1  serial line; asynchronous to clk; idles high.
- rx_data  output  8  last correctly framed byte; holds until the next good frame.
- rx_valid  output  1  one-cycle pulse; rx_data is new.
- frame_err  output  1  one-cycle pulse; the stop bit was sampled low.
- rx_busy  output  1  high in every state except IDLE.

## Operation
- Synchronisation:
  - rx_in passes through a 2-flop synchroniser to rx_s.
  - The flops reset to 1.
  - The FSM reads only rx_s.
- State machine, five states. The counter cnt is 16 bits and bit_idx is 3 bits.
  - IDLE:
    - If rx_s==0, go to START with cnt=0.
  - START:
    - cnt increments each cycle.
    - When cnt==HALF-1, sample rx_s.
    - If rx_s is 0, go to DATA with cnt=0 and bit_idx=0.
    - If rx_s is 1, treat it as a glitch and go to IDLE. No output pulses.
  - DATA:
    - cnt increments.
    - When cnt==CPB-1, shift rx_s into shreg[bit_idx] (LSB first) and set cnt=0.
    - After bit_idx==7, go to STOP. Otherwise increment bit_idx.
  - STOP:
    - When cnt==CPB-1, sample rx_s.
    - If rx_s is 1: rx_data<=shreg, pulse rx_valid, go to IDLE.
    - If rx_s is 0: pulse frame_err, leave rx_data unchanged, go to BREAK.
  - BREAK:
    - Wait until rx_s==1, then go to IDLE.
    - A line held low is never re-armed as a new start bit.
- There is no backpressure. The consumer must take rx_data within one frame time. A later good frame overwrites rx_data without warning.
- rx_valid and frame_err are never high in the same cycle.

## Timing
- Reset values:
  - rx_data=8'h00, rx_valid=0, frame_err=0, rx_busy=0.
  - State IDLE, cnt=0, bit_idx=0, shreg=0, synchroniser flops=1.
- Reset asserted mid-frame aborts immediately. No pulse is emitted and the partial byte is discarded.
- Let E0 be the first rising edge at which the synchroniser's first flop captures rx_in low.
  - IDLE→START occurs at E0+2.
  - The start-bit check happens at E0+2+HALF.
  - Data bit k is sampled at E0+2+HALF+(k+1)·CPB.
  - The stop bit is sampled at E0+2+HALF+9·CPB.
  - rx_valid or frame_err is high for exactly the cycle following that edge.
- After a good frame, IDLE is re-entered on the stop-sample edge. A falling edge arriving ½ bit after the stop-bit centre starts the next frame. Back-to-back frames with zero idle gap are received.
- A low pulse shorter than HALF-2 cycles is rejected as a glitch.
- cnt never exceeds CPB-1. No wrap-around is possible.

## Structure
- Package uart_pkg holds:
  - the FSM state encoding (IDLE, START, DATA, STOP, BREAK; 3-bit);
  - default CLK_FREQ/BAUD_RATE;
  - the frame constants DATA_BITS=8 and STOP_BITS=1.
- The package is shared with the transmitter.
- One sub-module, uart_sync: 2-flop synchroniser with a reset value parameter. It is reusable for other asynchronous inputs.
- Everything else lives in uart_rx: a single FSM process plus the output registers.

## Test plan
Run with CLK_FREQ=16, BAUD_RATE=1 (CPB=16, HALF=8) unless noted.
- Good frame: drive 8N1 frame 0xA5 with ideal bit timing. rx_data=0xA5 and rx_valid is a single-cycle pulse at E0+2+8+144. frame_err stays 0.
- Glitch: drive rx_in low for 3 cycles, then high. rx_busy pulses briefly and the FSM returns to IDLE. No rx_valid or frame_err. rx_data unchanged.
- Framing error: send 0x3C with stop bit 0 and hold the line low for 40 more cycles.
  - frame_err pulses once and rx_data keeps its prior value.
  - rx_busy stays high until the line returns high.
  - A following good 0x5A frame is then received.
- Back-to-back: send 0x00 then 0xFF with no idle gap. Two rx_valid pulses occur 160 cycles apart, with rx_data 0x00 then 0xFF.
- Reset mid-frame: assert rst during data bit 4 of 0x81, release, then send 0x42.
  - All outputs are at their reset values while rst is high.
  - No pulse comes from the aborted frame.
  - 0x42 is received correctly.
- Loopback at defaults (50 MHz/9600): connect the team's transmitter output to rx_in and send 0x00, 0x55, 0xFF. Each byte is received with rx_valid and frame_err=0.
